// File: rtl/qpu_exu_meas_hist_rf_pkg.sv
// Shared defaults and types for the per-qubit measurement history register file.
package qpu_exu_meas_hist_rf_pkg;

  localparam int unsigned QUBIT_NUM_DEF  = 12;
  localparam int unsigned HIST_DEPTH_DEF = 4;
  localparam int unsigned AGE_W_DEF      = $clog2(HIST_DEPTH_DEF);
  localparam int unsigned CNT_W_DEF      = $clog2(HIST_DEPTH_DEF + 1);

  typedef struct packed {
    logic rd_data;
    logic rd_valid;
    logic fb_zero;
    logic fb_one;
    logic fb_equ;
    logic ovf;
  } lane_out_t;

endpackage

// File: rtl/qpu_exu_meas_hist_rf_if.sv
// Bundle of measurement writeback, clear, FMR read and fast-feedback signals.
interface qpu_exu_meas_hist_rf_if
  import qpu_exu_meas_hist_rf_pkg::*;
#(
  parameter int unsigned QUBIT_NUM = QUBIT_NUM_DEF,
  parameter int unsigned AGE_W     = AGE_W_DEF
);

  logic                 meas_wen;
  logic [QUBIT_NUM-1:0] meas_list;
  logic [QUBIT_NUM-1:0] meas_data;
  logic                 clr_en;
  logic [QUBIT_NUM-1:0] clr_list;
  logic                 rd_ena;
  logic [QUBIT_NUM-1:0] rd_list;
  logic [AGE_W-1:0]     rd_age;
  logic [QUBIT_NUM-1:0] rd_data;
  logic [QUBIT_NUM-1:0] rd_valid;
  logic [QUBIT_NUM-1:0] fb_zero;
  logic [QUBIT_NUM-1:0] fb_one;
  logic [QUBIT_NUM-1:0] fb_equ;
  logic [QUBIT_NUM-1:0] hist_ovf;

  modport master (
    output meas_wen, meas_list, meas_data, clr_en, clr_list, rd_ena, rd_list, rd_age,
    input  rd_data, rd_valid, fb_zero, fb_one, fb_equ, hist_ovf
  );

  modport slave (
    input  meas_wen, meas_list, meas_data, clr_en, clr_list, rd_ena, rd_list, rd_age,
    output rd_data, rd_valid, fb_zero, fb_one, fb_equ, hist_ovf
  );

endinterface

// File: rtl/qpu_exu_meas_hist_rf_lane.sv
// One qubit's result ring: write pointer, saturating valid count, sticky overflow,
// age-indexed read and same-cycle bypassed feedback flags.
module qpu_exu_meas_hist_rf_lane
  import qpu_exu_meas_hist_rf_pkg::*;
#(
  parameter int unsigned HIST_DEPTH = HIST_DEPTH_DEF,
  parameter int unsigned AGE_W      = AGE_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic             i_clr,
  input  logic             i_data,
  input  logic             i_rd_en,
  input  logic [AGE_W-1:0] i_rd_age,
  output lane_out_t        o_lane
);

  logic [HIST_DEPTH-1:0] r_ring;
  logic [AGE_W-1:0]      r_wptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf;

  logic [AGE_W-1:0] w_wptr_base;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_ovf_base;
  logic             w_full;
  logic [AGE_W-1:0] w_newest_idx;
  logic [AGE_W-1:0] w_prev_idx;
  logic [AGE_W-1:0] w_rd_idx;
  logic             w_cnt_nz;
  logic             w_cnt_ge2;
  logic             w_new;
  logic             w_prev;
  logic             w_has1;
  logic             w_has2;
  logic             w_rd_valid;

  // A same-cycle clear is applied before the write by rebasing on zeroed state.
  assign w_wptr_base = i_clr ? '0 : r_wptr;
  assign w_cnt_base  = i_clr ? '0 : r_cnt;
  assign w_ovf_base  = i_clr ? 1'b0 : r_ovf;
  assign w_full      = (w_cnt_base == CNT_W'(HIST_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ring <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else if (i_we) begin
      r_ring[w_wptr_base] <= i_data;
      r_wptr              <= w_wptr_base + AGE_W'(1);
      r_cnt               <= w_full ? w_cnt_base : w_cnt_base + CNT_W'(1);
      r_ovf               <= w_ovf_base | w_full;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end
  end

  assign w_newest_idx = r_wptr - AGE_W'(1);
  assign w_prev_idx   = r_wptr - AGE_W'(2);
  assign w_rd_idx     = r_wptr - AGE_W'(1) - i_rd_age;
  assign w_cnt_nz     = (r_cnt != '0);
  assign w_cnt_ge2    = (r_cnt >= CNT_W'(2));
  assign w_rd_valid   = i_rd_en & (CNT_W'(i_rd_age) < r_cnt);

  // Bypass: an incoming write becomes the newest entry; with a clear it is the only one.
  assign w_new  = i_we ? i_data : r_ring[w_newest_idx];
  assign w_prev = i_we ? r_ring[w_newest_idx] : r_ring[w_prev_idx];
  assign w_has1 = i_we | w_cnt_nz;
  assign w_has2 = i_we ? (~i_clr & w_cnt_nz) : w_cnt_ge2;

  always_comb begin
    o_lane = '0;
    if (rst_n) begin
      o_lane.rd_valid = w_rd_valid;
      o_lane.rd_data  = w_rd_valid & r_ring[w_rd_idx];
      o_lane.fb_one   = w_has1 & w_new;
      o_lane.fb_zero  = w_has1 & ~w_new;
      o_lane.fb_equ   = w_has2 & (w_new == w_prev);
      o_lane.ovf      = r_ovf;
    end
  end

endmodule

// File: rtl/qpu_exu_meas_hist_rf.sv
// Measurement history register file: one independent lane per qubit, inputs
// broadcast bitwise and lane outputs packed back into qubit-indexed vectors.
module qpu_exu_meas_hist_rf
  import qpu_exu_meas_hist_rf_pkg::*;
#(
  parameter int unsigned QUBIT_NUM  = QUBIT_NUM_DEF,
  parameter int unsigned HIST_DEPTH = HIST_DEPTH_DEF,
  parameter int unsigned AGE_W      = $clog2(HIST_DEPTH),
  parameter int unsigned CNT_W      = $clog2(HIST_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  qpu_exu_meas_hist_rf_if.slave   bus
);

  lane_out_t            w_lane [QUBIT_NUM];
  logic [QUBIT_NUM-1:0] w_rd_data;
  logic [QUBIT_NUM-1:0] w_rd_valid;
  logic [QUBIT_NUM-1:0] w_fb_zero;
  logic [QUBIT_NUM-1:0] w_fb_one;
  logic [QUBIT_NUM-1:0] w_fb_equ;
  logic [QUBIT_NUM-1:0] w_ovf;

  for (genvar k = 0; k < QUBIT_NUM; k++) begin : g_lane
    qpu_exu_meas_hist_rf_lane #(
      .HIST_DEPTH (HIST_DEPTH),
      .AGE_W      (AGE_W),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (bus.meas_wen & bus.meas_list[k]),
      .i_clr    (bus.clr_en & bus.clr_list[k]),
      .i_data   (bus.meas_data[k]),
      .i_rd_en  (bus.rd_ena & bus.rd_list[k]),
      .i_rd_age (bus.rd_age),
      .o_lane   (w_lane[k])
    );
  end

  always_comb begin
    w_rd_data  = '0;
    w_rd_valid = '0;
    w_fb_zero  = '0;
    w_fb_one   = '0;
    w_fb_equ   = '0;
    w_ovf      = '0;
    for (int k = 0; k < QUBIT_NUM; k++) begin
      w_rd_data[k]  = w_lane[k].rd_data;
      w_rd_valid[k] = w_lane[k].rd_valid;
      w_fb_zero[k]  = w_lane[k].fb_zero;
      w_fb_one[k]   = w_lane[k].fb_one;
      w_fb_equ[k]   = w_lane[k].fb_equ;
      w_ovf[k]      = w_lane[k].ovf;
    end
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_valid = w_rd_valid;
  assign bus.fb_zero  = w_fb_zero;
  assign bus.fb_one   = w_fb_one;
  assign bus.fb_equ   = w_fb_equ;
  assign bus.hist_ovf = w_ovf;

endmodule

// File: tb/tb_qpu_exu_meas_hist_rf.sv
// Scoreboard bench: an age-ordered history model predicts every output each cycle,
// a negedge monitor compares; a few fixed-value checks pin down the key scenarios.
module tb_qpu_exu_meas_hist_rf;
  import qpu_exu_meas_hist_rf_pkg::*;

  localparam int QN = 12;
  localparam int HD = 4;
  localparam int AW = 2;
  localparam logic [QN-1:0] ALL = '1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qpu_exu_meas_hist_rf_if #(.QUBIT_NUM(QN), .AGE_W(AW)) bus ();

  qpu_exu_meas_hist_rf #(.QUBIT_NUM(QN), .HIST_DEPTH(HD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [QN-1:0] rd_data;
    logic [QN-1:0] rd_valid;
    logic [QN-1:0] fz;
    logic [QN-1:0] fo;
    logic [QN-1:0] fe;
    logic [QN-1:0] ovf;
  } exp_t;

  exp_t sb[$];

  // hist[k][0] is the newest result of qubit k; hcnt[k] entries are valid
  bit hist [QN][HD];
  int hcnt [QN];
  bit movf [QN];

  logic          c_rst, c_wen, c_ce, c_re;
  logic [QN-1:0] c_wl, c_wd, c_cl, c_rl;
  logic [AW-1:0] c_ra;

  function automatic void model_commit();
    for (int k = 0; k < QN; k++) begin
      if (!c_rst) begin
        hcnt[k] = 0;
        movf[k] = 1'b0;
        for (int j = 0; j < HD; j++) hist[k][j] = 1'b0;
      end else begin
        if (c_ce && c_cl[k]) begin
          hcnt[k] = 0;
          movf[k] = 1'b0;
        end
        if (c_wen && c_wl[k]) begin
          if (hcnt[k] == HD) movf[k] = 1'b1;
          for (int j = HD - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
          hist[k][0] = c_wd[k];
          if (hcnt[k] < HD) hcnt[k]++;
        end
      end
    end
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    bit   we, cl, nw, has2;
    e = '0;
    if (c_rst) begin
      for (int k = 0; k < QN; k++) begin
        we = c_wen && c_wl[k];
        cl = c_ce && c_cl[k];
        e.rd_valid[k] = c_re && c_rl[k] && (int'(c_ra) < hcnt[k]);
        e.rd_data[k]  = e.rd_valid[k] && hist[k][c_ra];
        if (we) begin
          nw   = c_wd[k];
          has2 = !cl && hcnt[k] >= 1;
          e.fo[k] = nw;
          e.fz[k] = !nw;
          e.fe[k] = has2 && (nw == hist[k][0]);
        end else begin
          e.fo[k] = hcnt[k] >= 1 && hist[k][0];
          e.fz[k] = hcnt[k] >= 1 && !hist[k][0];
          e.fe[k] = hcnt[k] >= 2 && (hist[k][0] == hist[k][1]);
        end
        e.ovf[k] = movf[k];
      end
    end
    return e;
  endfunction

  task automatic cmp(input string name, input logic [QN-1:0] got, input logic [QN-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic wen, input logic [QN-1:0] wl,
                       input logic [QN-1:0] wd, input logic ce, input logic [QN-1:0] cl,
                       input logic re, input logic [QN-1:0] rl, input logic [AW-1:0] ra);
    @(posedge clk);
    model_commit();
    #1;
    c_rst = rst; c_wen = wen; c_wl = wl; c_wd = wd; c_ce = ce; c_cl = cl;
    c_re = re; c_rl = rl; c_ra = ra;
    rst_n         = rst;
    bus.meas_wen  = wen;
    bus.meas_list = wl;
    bus.meas_data = wd;
    bus.clr_en    = ce;
    bus.clr_list  = cl;
    bus.rd_ena    = re;
    bus.rd_list   = rl;
    bus.rd_age    = ra;
    sb.push_back(model_expect());
  endtask

  task automatic wr(input int q, input bit b);
    logic [QN-1:0] m;
    m = QN'(1) << q;
    drive(1'b1, 1'b1, m, b ? m : '0, 1'b0, '0, 1'b1, ALL, '0);
  endtask

  task automatic rd(input logic [QN-1:0] rl, input logic [AW-1:0] ra);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1, rl, ra);
  endtask

  task automatic chk_bit(input string name, input logic got, input logic want);
    #2;
    cmp(name, QN'(got), QN'(want));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp("rd_data",  bus.rd_data,  e.rd_data);
      cmp("rd_valid", bus.rd_valid, e.rd_valid);
      cmp("fb_zero",  bus.fb_zero,  e.fz);
      cmp("fb_one",   bus.fb_one,   e.fo);
      cmp("fb_equ",   bus.fb_equ,   e.fe);
      cmp("hist_ovf", bus.hist_ovf, e.ovf);
    end
  end

  initial begin
    bit d2 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit v2 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit d3 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit w3 [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [QN-1:0] m2;

    c_rst = 1'b0; c_wen = 1'b1; c_wl = ALL; c_wd = ALL; c_ce = 1'b0; c_cl = '0;
    c_re = 1'b1; c_rl = ALL; c_ra = '0;
    rst_n = 1'b0;
    bus.meas_wen = 1'b1; bus.meas_list = ALL; bus.meas_data = ALL;
    bus.clr_en = 1'b0; bus.clr_list = '0;
    bus.rd_ena = 1'b1; bus.rd_list = ALL; bus.rd_age = '0;

    // reset held with writes pending
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, ALL, ALL, 1'b0, '0, 1'b1, ALL, '0);
      #2;
      cmp("rst_fb_one", bus.fb_one, '0);
    end
    rd(ALL, '0);
    #2;
    cmp("post_rst_valid", bus.rd_valid, '0);

    // qubit 3: 1,0,1 then age reads
    wr(3, 1'b1); wr(3, 1'b0); wr(3, 1'b1);
    for (int a = 0; a < 4; a++) begin
      rd(QN'(12'h008), AW'(a));
      #2;
      cmp("q3_rd_data",  QN'(bus.rd_data[3]),  QN'(d2[a]));
      cmp("q3_rd_valid", QN'(bus.rd_valid[3]), QN'(v2[a]));
    end

    // qubit 0: five writes wrap and set overflow
    for (int i = 0; i < 5; i++) wr(0, w3[i]);
    for (int a = 0; a < 4; a++) begin
      rd(QN'(1), AW'(a));
      #2;
      cmp("q0_rd_data",  QN'(bus.rd_data[0]),  QN'(d3[a]));
      cmp("q0_rd_valid", QN'(bus.rd_valid[0]), QN'(1));
      cmp("q0_ovf",      QN'(bus.hist_ovf[0]), QN'(1));
    end

    // qubit 5 bypass equality
    wr(5, 1'b1); wr(5, 1'b0);
    wr(5, 1'b0);
    #2;
    cmp("q5_byp_zero", QN'(bus.fb_zero[5]), QN'(1));
    cmp("q5_byp_equ",  QN'(bus.fb_equ[5]),  QN'(1));
    rd('0, '0);
    chk_bit("q5_ring_equ", bus.fb_equ[5], 1'b1);

    // qubit 7 empty, then first write
    rd('0, '0);
    #2;
    cmp("q7_empty_fb", QN'({bus.fb_zero[7], bus.fb_one[7], bus.fb_equ[7]}), QN'(0));
    wr(7, 1'b1);
    #2;
    cmp("q7_first_one", QN'(bus.fb_one[7]), QN'(1));
    cmp("q7_first_equ", QN'(bus.fb_equ[7]), QN'(0));

    // qubit 2 overflowed; clear on qubit 4 must not touch it; then clear+write on qubit 2
    for (int i = 0; i < 5; i++) wr(2, 1'b0);
    wr(4, 1'b1);
    drive(1'b1, 1'b0, '0, '0, 1'b1, QN'(12'h010), 1'b1, ALL, '0);
    rd(ALL, '0);
    #2;
    cmp("q2_ovf_kept", QN'(bus.hist_ovf[2]), QN'(1));
    cmp("q4_cleared",  QN'(bus.rd_valid[4]), QN'(0));
    m2 = QN'(12'h004);
    drive(1'b1, 1'b1, m2, m2, 1'b1, m2, 1'b0, '0, '0);
    #2;
    cmp("q2_clrwr_equ", QN'(bus.fb_equ[2]), QN'(0));
    rd(m2, '0);
    #2;
    cmp("q2_age0_data", QN'(bus.rd_data[2]),  QN'(1));
    cmp("q2_ovf_clr",   QN'(bus.hist_ovf[2]), QN'(0));
    rd(m2, AW'(1));
    #2;
    cmp("q2_age1_valid", QN'(bus.rd_valid[2]), QN'(0));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(logic'($urandom_range(63) != 0), logic'($urandom_range(1)), QN'($urandom),
            QN'($urandom), logic'($urandom_range(7) == 0), QN'($urandom),
            logic'($urandom_range(3) != 0), QN'($urandom), AW'($urandom));
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
